// File: rtl/cordic_pkg.sv
`default_nettype none
// ---- cordic_pkg : shared CORDIC constants and id-width helper ---- rev 1.0 ----
package cordic_pkg;
  localparam int CORDIC_W    = 32;
  localparam int CORDIC_LAT  = 17;
  localparam int CORDIC_FRAC = 16;
  localparam int INFLIGHT_W  = 6;

  // One bit minimum so a single-requester build still has a legal id port.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage
`default_nettype wire

// File: rtl/cordic_tag_pipe.sv
`default_nettype none
// ---- cordic_tag_pipe : DEPTH-stage shift register carrying issue tags ---- rev 1.0 ----
module cordic_tag_pipe #(
  parameter int DEPTH = 17,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  logic [DEPTH*W-1:0] shreg;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shreg <= '0;
        else        shreg <= din;
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) shreg <= '0;
        else        shreg <= {shreg[(DEPTH-1)*W-1:0], din};
      end
    end
  endgenerate

  assign dout = shreg[DEPTH*W-1 -: W];
endmodule
`default_nettype wire

// File: rtl/cordic_arbiter.sv
`default_nettype none
// ---- cordic_arbiter : round-robin sharing of one pipelined CORDIC ---- rev 1.0 ----
module cordic_arbiter
  import cordic_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int CDC_LAT = CORDIC_LAT
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [CORDIC_W*NUM_REQ-1:0]   req_x0,
  input  logic [CORDIC_W*NUM_REQ-1:0]   req_y0,
  input  logic [CORDIC_W*NUM_REQ-1:0]   req_z0,
  output logic [CORDIC_W-1:0]           cdc_x0,
  output logic [CORDIC_W-1:0]           cdc_y0,
  output logic [CORDIC_W-1:0]           cdc_z0,
  input  logic [CORDIC_W-1:0]           cdc_x,
  input  logic [CORDIC_W-1:0]           cdc_y,
  output logic                          resp_valid,
  output logic [id_width(NUM_REQ)-1:0]  resp_id,
  output logic [CORDIC_W-1:0]           resp_x,
  output logic [CORDIC_W-1:0]           resp_y,
  output logic [INFLIGHT_W-1:0]         inflight,
  output logic                          idle
);
  localparam int ID_W = id_width(NUM_REQ);
  localparam logic [INFLIGHT_W-1:0] INFLIGHT_MAX = INFLIGHT_W'(CDC_LAT + 1);

  logic [NUM_REQ-1:0] grant;
  logic               gnt_any;
  int                 gnt_idx;
  int                 probe;
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    iss_id;
  logic               iss_valid;
  logic               xfer;
  logic [ID_W:0]      tag_tail;

  always_comb begin
    grant   = '0;
    gnt_any = 1'b0;
    gnt_idx = 0;
    probe   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe = (int'(rr_ptr) + k) % NUM_REQ;
      if (!gnt_any && req_valid[probe]) begin
        gnt_any        = 1'b1;
        gnt_idx        = probe;
        grant[probe]   = 1'b1;
      end
    end
  end

  // rst_n gates ready so nothing is offered while reset is held.
  assign req_ready = grant & {NUM_REQ{en & rst_n}};
  assign xfer      = |(req_valid & req_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdc_x0    <= '0;
      cdc_y0    <= '0;
      cdc_z0    <= '0;
      iss_valid <= 1'b0;
      iss_id    <= '0;
      rr_ptr    <= '0;
    end else begin
      iss_valid <= xfer;
      if (xfer) begin
        cdc_x0 <= req_x0[gnt_idx*CORDIC_W +: CORDIC_W];
        cdc_y0 <= req_y0[gnt_idx*CORDIC_W +: CORDIC_W];
        cdc_z0 <= req_z0[gnt_idx*CORDIC_W +: CORDIC_W];
        iss_id <= ID_W'(gnt_idx);
        rr_ptr <= ID_W'((gnt_idx + 1) % NUM_REQ);
      end
    end
  end

  // Tags ride alongside the CORDIC pipe; resetting them drops orphaned results.
  cordic_tag_pipe #(
    .DEPTH (CDC_LAT),
    .W     (ID_W + 1)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({iss_valid, iss_id}),
    .dout  (tag_tail)
  );

  assign resp_valid = tag_tail[ID_W];
  assign resp_id    = tag_tail[ID_W-1:0];
  assign resp_x     = cdc_x;
  assign resp_y     = cdc_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= '0;
    end else begin
      case ({xfer, resp_valid})
        2'b10:   if (inflight != INFLIGHT_MAX) inflight <= inflight + 1'b1;
        2'b01:   if (inflight != '0)           inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  assign idle = (inflight == '0) && !iss_valid;
endmodule
`default_nettype wire

// File: tb/tb_cordic_arbiter.sv
`default_nettype none
// ---- tb_cordic_arbiter : directed self-checking bench with a real-math CORDIC stand-in ---- rev 1.0 ----
module tb_cordic_arbiter;
  localparam int NUM_REQ = 2;
  localparam int LAT     = 17;
  localparam real K_GAIN = 1.646760258;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   en = 1'b0;
  logic [NUM_REQ-1:0]     req_valid = '0;
  logic [NUM_REQ-1:0]     req_ready;
  logic [32*NUM_REQ-1:0]  req_x0 = '0, req_y0 = '0, req_z0 = '0;
  logic [31:0]            cdc_x0, cdc_y0, cdc_z0;
  logic [31:0]            cdc_x, cdc_y;
  logic                   resp_valid;
  logic [0:0]             resp_id;
  logic [31:0]            resp_x, resp_y;
  logic [5:0]             inflight;
  logic                   idle;

  int tests = 0;
  int fails = 0;

  cordic_arbiter #(.NUM_REQ(NUM_REQ), .CDC_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x0(req_x0), .req_y0(req_y0), .req_z0(req_z0),
    .cdc_x0(cdc_x0), .cdc_y0(cdc_y0), .cdc_z0(cdc_z0),
    .cdc_x(cdc_x), .cdc_y(cdc_y),
    .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_x(resp_x), .resp_y(resp_y),
    .inflight(inflight), .idle(idle)
  );

  always #5 clk = ~clk;

  // Rotation-mode CORDIC behaviour (gain included), LAT cycles deep, no reset.
  function automatic logic [31:0] rot(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z, input bit want_y);
    real xr, yr, a, r;
    int  ri;
    xr = $itor($signed(x));
    yr = $itor($signed(y));
    a  = $itor($signed(z)) / 65536.0;
    if (want_y) r = K_GAIN * (yr * $cos(a) + xr * $sin(a));
    else        r = K_GAIN * (xr * $cos(a) - yr * $sin(a));
    ri = $rtoi(r);
    return ri;
  endfunction

  logic [31:0] mx [LAT];
  logic [31:0] my [LAT];
  always @(posedge clk) begin
    mx[0] <= rot(cdc_x0, cdc_y0, cdc_z0, 1'b0);
    my[0] <= rot(cdc_x0, cdc_y0, cdc_z0, 1'b1);
    for (int i = 1; i < LAT; i++) begin
      mx[i] <= mx[i-1];
      my[i] <= my[i-1];
    end
  end
  assign cdc_x = mx[LAT-1];
  assign cdc_y = my[LAT-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input logic [31:0] obs, input int exp, input int tol);
    int d;
    d = $signed(obs) - exp;
    tests++;
    assert (((d <= tol) && (d >= -tol)) === 1'b1) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d+-%0d", tag, $signed(obs), exp, tol);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    req_x0[32*i +: 32] = x;
    req_y0[32*i +: 32] = y;
    req_z0[32*i +: 32] = z;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    en        = 1'b0;
    req_valid = '0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_idle", idle, 1);
    check("rst_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_inflight", inflight, 0);
    check("rst_cdc_x0", cdc_x0, 0);
    check("rst_cdc_z0", cdc_z0, 0);

    // Single op at 30 degrees; transfer cycle is cycle 0, response in cycle 18
    do_reset();
    en = 1'b1;
    set_op(0, 39797, 0, 34315);
    req_valid = 2'b01;
    #1;
    check("t1_ready", req_ready, 2'b01);
    tick();
    req_valid = 2'b00;
    #1;
    check("t1_cdc_x0", cdc_x0, 39797);
    check("t1_cdc_z0", cdc_z0, 34315);
    check("t1_inflight", inflight, 1);
    check("t1_idle", idle, 0);
    for (int n = 1; n <= 17; n++) begin
      tick();
      check("t1_resp_valid", resp_valid, (n == 17) ? 1 : 0);
    end
    check("t1_resp_id", resp_id, 0);
    check_near("t1_resp_x", resp_x, 56756, 4);
    check_near("t1_resp_y", resp_y, 32768, 4);
    tick();
    check("t1_resp_done", resp_valid, 0);
    check("t1_inflight_end", inflight, 0);
    check("t1_idle_end", idle, 1);

    // Contention: both requesters valid for 6 cycles
    do_reset();
    en = 1'b1;
    set_op(0, 39797, 0, 34315);
    set_op(1, 65536, 0, 0);
    req_valid = 2'b11;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t2_grant", req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end
    req_valid = 2'b00;
    #1;
    check("t2_inflight", inflight, 6);
    repeat (12) tick();
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t2_resp_valid", resp_valid, 1);
      check("t2_resp_id", resp_id, k % 2);
      tick();
    end
    #1;
    check("t2_resp_done", resp_valid, 0);

    // Streaming: requester 1 alone for 20 cycles
    do_reset();
    en = 1'b1;
    set_op(1, 39797, 0, 0);
    req_valid = 2'b10;
    for (int c = 0; c < 20; c++) begin
      #1;
      check("t3_ready", req_ready, 2'b10);
      check("t3_inflight", inflight, (c < 18) ? c : 18);
      check("t3_resp_valid", resp_valid, (c >= 18) ? 1 : 0);
      tick();
    end
    req_valid = 2'b00;
    for (int c = 20; c <= 38; c++) begin
      #1;
      check("t3_drain_valid", resp_valid, (c <= 37) ? 1 : 0);
      if (c == 37) check("t3_idle_last", idle, 0);
      if (c == 38) check("t3_idle_after", idle, 1);
      tick();
    end

    // en drop after 3 accepts
    do_reset();
    en = 1'b1;
    set_op(0, 39797, 0, 34315);
    req_valid = 2'b01;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t4_ready_on", req_ready, 2'b01);
      tick();
    end
    en = 1'b0;
    req_valid = 2'b11;
    for (int c = 3; c <= 21; c++) begin
      #1;
      check("t4_ready_off", req_ready, 0);
      check("t4_resp_valid", resp_valid, (c >= 18 && c <= 20) ? 1 : 0);
      if (c == 20) check("t4_idle_last", idle, 0);
      if (c == 21) begin
        check("t4_idle_after", idle, 1);
        check("t4_inflight_end", inflight, 0);
      end
      tick();
    end

    // Reset with 10 operations in flight
    do_reset();
    en = 1'b1;
    set_op(0, 39797, 0, 34315);
    req_valid = 2'b01;
    repeat (10) tick();
    #1;
    check("t5_inflight_pre", inflight, 10);
    rst_n = 1'b0;
    #1;
    check("t5_rst_ready", req_ready, 0);
    check("t5_rst_inflight", inflight, 0);
    check("t5_rst_idle", idle, 1);
    tick();
    tick();
    rst_n = 1'b1;
    req_valid = 2'b00;
    for (int c = 0; c < 20; c++) begin
      #1;
      check("t5_no_resp", resp_valid, 0);
      tick();
    end
    check("t5_inflight_end", inflight, 0);
    check("t5_idle_end", idle, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cordic_arbiter.md
CORDIC_ARBITER -- requirements
Module: cordic_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 2, giving the number of requesters sharing one pipelined CORDIC.
REQ-002 The block SHALL have parameter CDC_LAT, default 17, giving the CORDIC latency in cycles from x0/y0/z0 sampled to x/y valid.
REQ-003 The block SHALL have port clk, input, 1, the single clock; one clock, asynchronous active-low reset.
REQ-004 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port en, input, 1; when 0, no new grants.
REQ-006 The block SHALL have port req_valid, input, NUM_REQ; per-requester operand valid.
REQ-007 The block SHALL have port req_ready, output, NUM_REQ; per-requester accept.
REQ-008 The block SHALL have ports req_x0/req_y0/req_z0, input, 32*NUM_REQ each; packed operands, Q16.16 signed, requester i at bits [32i+31:32i].
REQ-009 The block SHALL have ports cdc_x0/cdc_y0/cdc_z0, output, 32 each; registered operands to the CORDIC.
REQ-010 The block SHALL have ports cdc_x/cdc_y, input, 32 each; CORDIC results.
REQ-011 The block SHALL have port resp_valid, output, 1; result valid, with no backpressure.
REQ-012 The block SHALL have port resp_id, output, clog2(NUM_REQ); owner of the result.
REQ-013 The block SHALL have ports resp_x/resp_y, output, 32 each; result data.
REQ-014 The block SHALL have port inflight, output, 6; count of accepted but not yet returned operations.
REQ-015 The block SHALL have port idle, output, 1; high when inflight==0 and no issue is pending.

Function
REQ-016 Arbitration SHALL be round-robin: search starts at rr_ptr; the first i with req_valid[i] is granted; after a grant, rr_ptr = (i+1) mod NUM_REQ.
REQ-017 req_ready[i] SHALL be en AND grant[i]; at most one bit is high per cycle; a transfer occurs when req_valid[i] AND req_ready[i].
REQ-018 req_valid SHALL NOT depend on req_ready; a requester SHALL hold its operands stable until accepted.
REQ-019 On a transfer, the accepted operands SHALL be registered into cdc_x0/y0/z0 on the next clk edge, and iss_valid/iss_id SHALL be set.
REQ-020 With no transfer, iss_valid SHALL be 0 and cdc_* SHALL hold their previous value.
REQ-021 A tag delay line of CDC_LAT stages SHALL carry {iss_valid, iss_id} aligned with the CORDIC pipeline.
REQ-022 resp_valid SHALL equal the tail valid of the delay line.
REQ-023 resp_id SHALL equal the tail id of the delay line.
REQ-024 resp_x/resp_y SHALL be cdc_x/cdc_y passed through combinationally.
REQ-025 Latency from transfer edge to resp_valid SHALL be exactly CDC_LAT+1 = 18 cycles.
REQ-026 Throughput SHALL be one operation per cycle, back-to-back, for one or many requesters.
REQ-027 inflight SHALL increment on a transfer, decrement on resp_valid, and be unchanged when both occur in the same cycle.
REQ-028 inflight SHALL saturate logically at CDC_LAT+1 (18), which is never exceeded by construction.
REQ-029 When en deasserts mid-stream, no new grants SHALL occur; in-flight results SHALL still return.
REQ-030 idle SHALL rise the cycle after the last resp_valid.
REQ-031 rr_ptr SHALL advance only on a transfer; when en=0 or no requester is valid, rr_ptr SHALL hold.

Reset
REQ-032 On rst_n low (asynchronous), the following SHALL be cleared: cdc_x0/y0/z0=0, iss_valid=0, all delay-line tags=0, rr_ptr=0, inflight=0, resp_valid=0, resp_id=0; idle SHALL be 1 and req_ready SHALL be 0.
REQ-033 Because the CORDIC has no reset, results in flight at reset SHALL be discarded: no resp_valid SHALL be emitted for them.
REQ-034 Reset release SHALL be synchronous to clk; the first grant is possible on the first edge after release.

Structure
REQ-035 Package cordic_pkg SHALL hold CORDIC_W=32, CORDIC_LAT=17, CORDIC_FRAC=16, and the id width function.
REQ-036 The tag delay line SHALL be a sub-module named cordic_tag_pipe (parameters DEPTH, W; async active-low reset).
REQ-037 The CORDIC itself SHALL be instantiated outside the block; this block owns only the operand and result ports.

Verification
REQ-038 Single op: req0 x0=39797, y0=0, z0=34315 (30 deg) -> resp_valid exactly 18 cycles later, resp_id=0, resp_x=56756+-4, resp_y=32768+-4.
REQ-039 Contention: req0 and req1 both valid continuously for 6 cycles -> grants alternate 0,1,0,1,0,1; resp_id sequence identical; 6 consecutive resp_valid.
REQ-040 Streaming: req1 alone valid for 20 cycles -> req_ready[1]=1 every cycle; inflight reaches 18 then holds; resp_valid continuous from cycle 18.
REQ-041 en drop: en=0 after 3 accepts -> no further req_ready; 3 responses return; idle=1 one cycle after the third resp_valid.
REQ-042 Reset mid-flight: assert rst_n=0 with 10 ops in flight, release after 2 cycles -> zero resp_valid for 20 cycles; inflight=0; idle=1.
